// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - register file with two registered read ports and per-register pending bits
module register_file_scoreboard #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 3,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 writeEnable,
  input  logic [BITS_ADDR-1:0] dirrInput,
  input  logic [BITS_DATA-1:0] inputData,
  input  logic                 readEnable,
  input  logic [BITS_ADDR-1:0] dirrOutput1,
  input  logic [BITS_ADDR-1:0] dirrOutput2,
  output logic [BITS_DATA-1:0] outputData1,
  output logic [BITS_DATA-1:0] outputData2,
  output logic                 busy1,
  output logic                 busy2,
  input  logic                 reserveEnable,
  input  logic [BITS_ADDR-1:0] dirrReserve,
  output logic                 reserveFail,
  output logic [BITS_ADDR:0]   pendingCount
);

  localparam int NUM_REGS = 2 ** BITS_ADDR;

  logic [BITS_DATA-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  pendingNext;
  logic [BITS_ADDR:0]   countNext;
  logic                 writeValid;
  logic                 reserveValid;
  logic                 reserveGrant;
  logic                 reserveReject;
  logic [BITS_DATA-1:0] readData1;
  logic [BITS_DATA-1:0] readData2;
  logic                 readBusy1;
  logic                 readBusy2;

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign writeValid   = writeEnable && !((ZERO_REG != 0) && (dirrInput == '0));
  assign reserveValid = reserveEnable && !((ZERO_REG != 0) && (dirrReserve == '0));

  // A same-cycle write to the reserved address frees it first, so the reserve wins.
  assign reserveGrant  = reserveValid &&
                         (!pending[dirrReserve] || (writeValid && (dirrInput == dirrReserve)));
  assign reserveReject = reserveValid && !reserveGrant;

  always_comb begin
    pendingNext = pending;
    if (writeValid) pendingNext[dirrInput] = 1'b0;
    if (reserveGrant) pendingNext[dirrReserve] = 1'b1;
    countNext = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      countNext = countNext + {{BITS_ADDR{1'b0}}, pendingNext[i]};
    end
  end

  always_comb begin
    readData1 = regs[dirrOutput1];
    readData2 = regs[dirrOutput2];
    readBusy1 = pending[dirrOutput1];
    readBusy2 = pending[dirrOutput2];
    if ((BYPASS != 0) && writeValid && (dirrInput == dirrOutput1)) begin
      readData1 = inputData;
      readBusy1 = pendingNext[dirrOutput1];
    end
    if ((BYPASS != 0) && writeValid && (dirrInput == dirrOutput2)) begin
      readData2 = inputData;
      readBusy2 = pendingNext[dirrOutput2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending      <= '0;
      outputData1  <= '0;
      outputData2  <= '0;
      busy1        <= 1'b0;
      busy2        <= 1'b0;
      reserveFail  <= 1'b0;
      pendingCount <= '0;
    end else begin
      if (writeValid) regs[dirrInput] <= inputData;
      pending      <= pendingNext;
      pendingCount <= countNext;
      reserveFail  <= reserveReject;
      if (readEnable) begin
        outputData1 <= readData1;
        outputData2 <= readData2;
        busy1       <= readBusy1;
        busy2       <= readBusy2;
      end
    end
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised general-purpose register file: one write port, two registered read ports, and a per-register pending (scoreboard) bit.
- Sits between decode and writeback in the CPU datapath.
- Decode reserves the destination register. Writeback clears the reservation when it writes.
- Readers see data plus a busy flag so the control unit can stall on hazards.

Parameters:
- BITS_DATA, 32: width of each register and of the data ports.
- BITS_ADDR, 3: register address width; register count NUM_REGS = 2**BITS_ADDR.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero (writes and reservations ignored); 0 = register 0 is ordinary.
- BYPASS, 1: 1 = a read in the same cycle as a write to the same address returns the new data; 0 = it returns the old data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- writeEnable  in  1  write request from writeback.
- dirrInput  in  BITS_ADDR  write address.
- inputData  in  BITS_DATA  write data.
- readEnable  in  1  capture both read ports this cycle.
- dirrOutput1  in  BITS_ADDR  read address, port 1.
- dirrOutput2  in  BITS_ADDR  read address, port 2.
- outputData1  out  BITS_DATA  registered read data, port 1.
- outputData2  out  BITS_DATA  registered read data, port 2.
- busy1  out  1  registered pending flag for the port-1 address.
- busy2  out  1  registered pending flag for the port-2 address.
- reserveEnable  in  1  reserve a destination register (set its pending bit).
- dirrReserve  in  BITS_ADDR  register to reserve.
- reserveFail  out  1  one-cycle pulse: reservation rejected.
- pendingCount  out  BITS_ADDR+1  number of registers currently pending.

Behaviour:
- Reset: on any rising edge with rst_n=0, the following all go to 0:
  - all registers and all pending bits;
  - outputData1/2, busy1/2, reserveFail, pendingCount.
  - Reset overrides every concurrent request; a reset mid-operation discards in-flight writes and reservations.
- Write: writeEnable=1 stores inputData into register dirrInput and clears that register's pending bit, same edge.
  - With ZERO_REG=1 and dirrInput=0, the write is ignored and register 0 stays 0.
- Reserve: reserveEnable=1 with dirrReserve not pending sets its pending bit.
  - If the register is already pending (pre-edge value), no state change and reserveFail=1 for exactly the next cycle.
  - Exception: a same-cycle write to the same address clears that bit first, so the reserve succeeds and the bit ends at 1.
  - With ZERO_REG=1 and dirrReserve=0: no effect and no fail.
- Read latency is 1 cycle. On an edge with readEnable=1:
  - outputDataN captures register[dirrOutputN] and busyN captures the pending bit.
  - With readEnable=0, outputs hold their previous values.
- Same-cycle read and write to the same address:
  - BYPASS=1: outputDataN gets inputData; busyN takes the post-write pending value.
  - BYPASS=0: outputDataN gets the old contents; busyN takes the pre-edge pending value.
- Register 0 with ZERO_REG=1 always reads 0 with busy=0.
- Both read ports are independent and may address the same register.
- pendingCount is registered and equals the population count of the post-edge pending vector; range 0..NUM_REGS.
- No other state machine. Each register's pending bit is a two-state FSM:
  - FREE -> PENDING on a successful reserve.
  - PENDING -> FREE on a write, unless a reserve to the same address occurs in the same cycle (the bit stays PENDING).

Test Plan:
- Reset then read all 8 addresses with readEnable=1 -> every outputData=0, busy=0, pendingCount=0.
- Write 0xDEADBEEF to R5; next cycle read R5 on both ports -> outputData1=outputData2=0xDEADBEEF one cycle after readEnable.
- BYPASS=1: write 0x12345678 to R3 while reading R3 the same cycle -> outputData1=0x12345678. Repeat with BYPASS=0 (R3 previously 0x1) -> 0x00000001.
- Reserve R2, then reserve R2 again -> reserveFail=1 for one cycle, pendingCount=1. Then write 0xA5 to R2 while reserving R2 -> reserveFail=0, pendingCount stays 1, R2 reads 0xA5 with busy=1.
- ZERO_REG=1: write 0xFFFFFFFF to R0 and reserve R0 -> R0 reads 0, busy=0, reserveFail=0, pendingCount unchanged.
- Reserve R1, R4, R7; assert rst_n=0 for one edge during a write to R4 -> all registers 0, pendingCount=0, reserveFail=0 after the reset edge.
